// File: rtl/program_loader.sv
// Instruction-memory loader: receives a length/payload/checksum byte stream,
// writes the payload to consecutive addresses and releases the CPU on a good checksum.
module program_loader #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [8:0]            count;
    logic [7:0]            csum;
    logic [TW-1:0]         tcnt;
    logic                  accept;
    logic                  timeout;
    logic                  len_fire;
    logic                  wr_fire;
    logic                  stay_done;
    logic                  stay_error;

    always_comb begin
        busy = 1'b0;
        case (state)
            S_LEN, S_DATA, S_CHECK: busy = 1'b1;
            default:                busy = 1'b0;
        endcase
        in_ready = busy;
        accept   = in_valid & busy;
        timeout  = busy && (tcnt == TW'(TIMEOUT_CYCLES));

        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_LEN;
            end
            S_LEN: begin
                if (timeout)     next_state = S_ERROR;
                else if (accept) next_state = S_DATA;
            end
            S_DATA: begin
                if (timeout)                       next_state = S_ERROR;
                else if (accept && count == 9'd1)  next_state = S_CHECK;
            end
            S_CHECK: begin
                if (timeout)     next_state = S_ERROR;
                else if (accept) next_state = (in_data == csum) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (start) next_state = S_LEN;
            end
            default: next_state = S_IDLE;
        endcase

        len_fire   = (state == S_LEN)  && accept && !timeout;
        wr_fire    = (state == S_DATA) && accept && !timeout;
        // Status flags follow the state one cycle late, but drop on the restart edge itself.
        stay_done  = (state == S_DONE)  && (next_state == S_DONE);
        stay_error = (state == S_ERROR) && (next_state == S_ERROR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            count     <= '0;
            csum      <= '0;
            tcnt      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state <= next_state;

            if (busy && !accept && !timeout) tcnt <= tcnt + TW'(1);
            else                             tcnt <= '0;

            if (len_fire) begin
                count <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                addr  <= ADDR_WIDTH'(BASE_ADDR);
                csum  <= '0;
            end else if (wr_fire) begin
                count <= count - 9'd1;
                addr  <= addr + ADDR_WIDTH'(1);
                csum  <= csum ^ in_data;
            end

            mem_we <= wr_fire;
            if (wr_fire) begin
                mem_addr  <= addr;
                mem_wdata <= in_data;
            end

            done      <= stay_done;
            error     <= stay_error;
            cpu_reset <= !stay_done;
        end
    end

endmodule
